// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [AWIDTH-1:0] d_addr_i;
  logic [DWIDTH-1:0] d_wdata_i;
  logic [2:0]        d_funct3_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DWIDTH-1:0] d_rdata_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_wdata_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [2:0]        mem_funct3_o;
  logic [DWIDTH-1:0] mem_rdata_i;
  logic              busy_o;

  modport master (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o, busy_o
  );

  modport slave (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_funct3_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, one transaction in flight.
module mem_port_arbiter #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STARVE  = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [3:0]        starve_q, starve_d;
  logic              if_win, d_win, rvalid;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;

  // Combinational arbitration in IDLE; grants are gated by reset so nothing leaks out while it is held.
  always_comb begin
    if_win = rst && state_q == IDLE && bus.if_req_i && (!bus.d_req_i || starve_q == 4'(MAX_STARVE));
    d_win  = rst && state_q == IDLE && bus.d_req_i && !if_win;
    rvalid = state_q == WAIT && cnt_q == 3'd1;
    addr   = if_win ? bus.if_addr_i : d_win ? bus.d_addr_i : '0;
    wdata  = d_win ? bus.d_wdata_i : '0;
  end

  assign bus.if_gnt_o       = if_win;
  assign bus.d_gnt_o        = d_win;
  assign bus.mem_addr_o     = addr;
  assign bus.mem_wdata_o    = wdata;
  assign bus.mem_read_en_o  = if_win || (d_win && !bus.d_we_i);
  assign bus.mem_write_en_o = d_win && bus.d_we_i;
  assign bus.mem_funct3_o   = if_win ? 3'b010 : d_win ? bus.d_funct3_i : 3'b000;
  assign bus.if_rvalid_o    = rvalid && !owner_q;
  assign bus.d_rvalid_o     = rvalid && owner_q;
  assign bus.if_rdata_o     = (rvalid && !owner_q) ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o      = (rvalid && owner_q && !we_q) ? bus.mem_rdata_i : '0;
  assign bus.busy_o         = state_q == WAIT;

  // Next state: latch owner on grant, count latency down in WAIT, track fetch starvation in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    starve_d = starve_q;
    if (state_q == IDLE) begin
      starve_d = (if_win || !bus.if_req_i) ? 4'd0 :
                 (d_win && starve_q != 4'(MAX_STARVE)) ? starve_q + 4'd1 : starve_q;
      if (if_win || d_win) begin
        state_d = WAIT;
        cnt_d   = 3'(MEM_LATENCY);
        owner_d = d_win;
        we_d    = d_win && bus.d_we_i;
      end
    end else begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = IDLE;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at latency 1 and latency 3.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) b1 ();
  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) b3 ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(1), .MAX_STARVE(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(3), .MAX_STARVE(4)) u3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.if_req_i = 0; b1.if_addr_i = 0; b1.d_req_i = 0; b1.d_we_i = 0;
    b1.d_addr_i = 0; b1.d_wdata_i = 0; b1.d_funct3_i = 0; b1.mem_rdata_i = 0;
    b3.if_req_i = 0; b3.if_addr_i = 0; b3.d_req_i = 0; b3.d_we_i = 0;
    b3.d_addr_i = 0; b3.d_wdata_i = 0; b3.d_funct3_i = 0; b3.mem_rdata_i = 32'h55AA1234;
    // reset holds all outputs low even with a request present
    b1.if_req_i = 1;
    #3;
    chk("rst_if_gnt", b1.if_gnt_o, 0);
    chk("rst_rd_en", b1.mem_read_en_o, 0);
    chk("rst_busy", b1.busy_o, 0);
    chk("rst_addr", b1.mem_addr_o, 0);
    b1.if_req_i = 0;
    #9 rst = 1;
    // reset mid-operation on latency-3 instance
    cyc();
    b3.if_req_i = 1; b3.if_addr_i = 32'h01000100;
    #1 chk("t1_if_gnt", b3.if_gnt_o, 1);
    cyc();
    b3.if_req_i = 0;
    chk("t1_busy_pre", b3.busy_o, 1);
    b3.d_req_i = 1;
    rst = 0;
    #1;
    chk("t1_busy_rst", b3.busy_o, 0);
    chk("t1_d_gnt_rst", b3.d_gnt_o, 0);
    chk("t1_rd_en_rst", b3.mem_read_en_o, 0);
    chk("t1_rvalid_rst", b3.if_rvalid_o, 0);
    b3.d_req_i = 0;
    #1 rst = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t1_no_rvalid", b3.if_rvalid_o, 0);
    end
    // first post-reset request is granted immediately; this grant starts the latency test
    cyc();
    b3.if_req_i = 1; b3.if_addr_i = 32'h01000200;
    #1 chk("t1_regrant", b3.if_gnt_o, 1);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      b3.if_req_i = 0;
      b3.d_req_i = (k <= 4);
      #1;
      chk($sformatf("t5_d_gnt_%0d", k), b3.d_gnt_o, k == 4);
      chk($sformatf("t5_if_rv_%0d", k), b3.if_rvalid_o, k == 3);
      chk($sformatf("t5_d_rv_%0d", k), b3.d_rvalid_o, k == 7);
      if (k == 7) chk("t5_d_rdata", b3.d_rdata_o, 32'h55AA1234);
    end
    // single fetch at latency 1
    cyc();
    b1.if_req_i = 1; b1.if_addr_i = 32'h01000000; b1.mem_rdata_i = 32'h00000013;
    #1;
    chk("t2_if_gnt", b1.if_gnt_o, 1);
    chk("t2_rd_en", b1.mem_read_en_o, 1);
    chk("t2_wr_en", b1.mem_write_en_o, 0);
    chk("t2_funct3", b1.mem_funct3_o, 3'b010);
    chk("t2_addr", b1.mem_addr_o, 32'h01000000);
    cyc();
    b1.if_req_i = 0;
    #1;
    chk("t2_if_rvalid", b1.if_rvalid_o, 1);
    chk("t2_if_rdata", b1.if_rdata_o, 32'h00000013);
    chk("t2_d_rvalid", b1.d_rvalid_o, 0);
    chk("t2_busy", b1.busy_o, 1);
    cyc();
    chk("t2_rv_done", b1.if_rvalid_o, 0);
    chk("t2_rdata_0", b1.if_rdata_o, 0);
    chk("t2_idle", b1.busy_o, 0);
    // store
    b1.d_req_i = 1; b1.d_we_i = 1; b1.d_addr_i = 32'h01000010;
    b1.d_wdata_i = 32'hDEADBEEF; b1.d_funct3_i = 3'b010;
    #1;
    chk("t3_d_gnt", b1.d_gnt_o, 1);
    chk("t3_wr_en", b1.mem_write_en_o, 1);
    chk("t3_rd_en", b1.mem_read_en_o, 0);
    chk("t3_wdata", b1.mem_wdata_o, 32'hDEADBEEF);
    chk("t3_addr", b1.mem_addr_o, 32'h01000010);
    cyc();
    b1.d_req_i = 0; b1.d_we_i = 0;
    #1;
    chk("t3_wr_en_off", b1.mem_write_en_o, 0);
    chk("t3_d_rvalid", b1.d_rvalid_o, 1);
    chk("t3_d_rdata", b1.d_rdata_o, 0);
    // byte-unsigned load passthrough
    cyc();
    b1.d_req_i = 1; b1.d_funct3_i = 3'b100; b1.d_addr_i = 32'h01000003; b1.mem_rdata_i = 32'h000000A5;
    #1;
    chk("t6_funct3", b1.mem_funct3_o, 3'b100);
    chk("t6_addr", b1.mem_addr_o, 32'h01000003);
    chk("t6_rd_en", b1.mem_read_en_o, 1);
    cyc();
    b1.d_req_i = 0;
    #1;
    chk("t6_d_rvalid", b1.d_rvalid_o, 1);
    chk("t6_d_rdata", b1.d_rdata_o, 32'h000000A5);
    // starvation: both held, grants every 2 cycles as D,D,D,D,IF,...
    cyc();
    b1.if_req_i = 1; b1.d_req_i = 1; b1.d_funct3_i = 3'b010;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      #1;
      chk($sformatf("t4_gnt_%0d", k), {b1.if_gnt_o, b1.d_gnt_o},
          (k % 2) ? 2'b00 : (((k / 2) % 5 == 4) ? 2'b10 : 2'b01));
    end
    b1.if_req_i = 0; b1.d_req_i = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
